// File: rtl/frog_referee.sv
// ---------------------------------------------------------------------------
// frog_referee
// Game-rules stage that sits behind the frog position FSM. It scrolls an
// LFSR-generated hazard lane from the goal end toward the start, detects
// collisions and wins, keeps lives and a two-digit BCD score, drives the LED
// lane, and holds the position FSM in reset after every hit, win or game
// over so the frog returns to cell 0.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   i_frog        frog position (one-hot expected, not enforced)
//   i_restart     debounced level, only honoured while the game is over
//   o_frog_reset  level into the position FSM synchronous reset
//   o_hazard      hazard lane, start and goal cells always clear
//   o_led         lane display (registered, built from the next state)
//   o_lives       remaining lives
//   o_score_bcd   two BCD digits, [7:4] tens
//   o_hit_pulse   one-cycle pulse after a collision
//   o_win_pulse   one-cycle pulse after the goal is reached
//   o_game_over   high while the game is over
// ---------------------------------------------------------------------------
module frog_referee #(
    parameter int         N_CELLS     = 19,
    parameter int         TICK_DIV    = 25000000,
    parameter int         HOLD_CYCLES = 8,
    parameter int         LIVES_INIT  = 3,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CELLS-1:0] i_frog,
    input  logic               i_restart,
    output logic               o_frog_reset,
    output logic [N_CELLS-1:0] o_hazard,
    output logic [N_CELLS-1:0] o_led,
    output logic [1:0]         o_lives,
    output logic [7:0]         o_score_bcd,
    output logic               o_hit_pulse,
    output logic               o_win_pulse,
    output logic               o_game_over
);

    localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 2;
    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [N_CELLS-1:0] SAFE      = {1'b0, {(N_CELLS-2){1'b1}}, 1'b0};
    localparam logic [N_CELLS-1:0] ALL_ONES  = {N_CELLS{1'b1}};
    localparam logic [N_CELLS-1:0] ALL_ZERO  = {N_CELLS{1'b0}};

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    // Two-digit BCD increment with 99 -> 00 wrap.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] lo;
        logic [3:0] hi;
        if (v[3:0] == 4'd9) begin
            lo = 4'd0;
            if (v[7:4] == 4'd9) begin
                hi = 4'd0;
            end else begin
                hi = v[7:4] + 4'd1;
            end
        end else begin
            lo = v[3:0] + 4'd1;
            hi = v[7:4];
        end
        return {hi, lo};
    endfunction

    state_t               r_state;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [7:0]           r_lfsr;
    logic [N_CELLS-1:0]   r_sh;
    logic [1:0]           r_lives;
    logic [7:0]           r_score;
    logic                 r_frog_reset;
    logic [N_CELLS-1:0]   r_led;
    logic                 r_hit_pulse;
    logic                 r_win_pulse;
    logic                 r_game_over;

    state_t               w_state_nxt;
    logic [HOLD_W-1:0]    w_hold_nxt;
    logic [TICK_W-1:0]    w_tick_nxt;
    logic [7:0]           w_lfsr_nxt;
    logic [N_CELLS-1:0]   w_sh_nxt;
    logic [1:0]           w_lives_nxt;
    logic [7:0]           w_score_nxt;
    logic                 w_hit_nxt;
    logic                 w_win_nxt;
    logic [N_CELLS-1:0]   w_led_nxt;

    logic [N_CELLS-1:0]   w_hazard;
    logic                 w_collision;
    logic                 w_tick;
    logic                 w_nb;
    logic [N_CELLS-1:0]   w_sh_shift;
    logic                 w_lfsr_fb;

    assign w_hazard    = r_sh & SAFE;
    assign w_collision = |(i_frog & w_hazard);
    assign w_tick      = (r_state == ST_PLAY) && (r_tick_cnt == TICK_LAST);
    // A new hazard is only admitted when the two entry cells are empty, which
    // keeps at least two clear cells behind every hazard.
    assign w_nb        = r_lfsr[1] & r_lfsr[0] & ~r_sh[N_CELLS-1] & ~r_sh[N_CELLS-2];
    assign w_sh_shift  = {w_nb, r_sh[N_CELLS-1:1]};
    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Tick divider and LFSR advance; both only move while playing.
    always_comb begin
        w_tick_nxt = {TICK_W{1'b0}};
        w_lfsr_nxt = r_lfsr;
        if (r_state == ST_PLAY) begin
            if (w_tick) begin
                w_tick_nxt = {TICK_W{1'b0}};
            end else begin
                w_tick_nxt = r_tick_cnt + TICK_W'(1);
            end
        end else begin
            w_tick_nxt = {TICK_W{1'b0}};
        end
        // The all-zero state would lock up the LFSR; recover from it.
        if (r_lfsr == 8'h00) begin
            w_lfsr_nxt = LFSR_SEED;
        end else if (w_tick) begin
            w_lfsr_nxt = {r_lfsr[6:0], w_lfsr_fb};
        end else begin
            w_lfsr_nxt = r_lfsr;
        end
    end

    // Game FSM next-state, lane, lives, score and pulse decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_sh_nxt    = r_sh;
        w_lives_nxt = r_lives;
        w_score_nxt = r_score;
        w_hit_nxt   = 1'b0;
        w_win_nxt   = 1'b0;
        case (r_state)
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_PLAY;
                    w_hold_nxt  = {HOLD_W{1'b0}};
                end else begin
                    w_hold_nxt  = r_hold_cnt + HOLD_W'(1);
                end
            end
            ST_PLAY: begin
                // The shift still applies on a tick that coincides with a hit.
                if (w_tick) begin
                    w_sh_nxt = w_sh_shift;
                end else begin
                    w_sh_nxt = r_sh;
                end
                if (w_collision) begin
                    w_state_nxt = ST_HIT;
                    w_lives_nxt = r_lives - 2'd1;
                    w_hit_nxt   = 1'b1;
                end else if (i_frog[N_CELLS-1]) begin
                    w_state_nxt = ST_HOLD;
                    w_sh_nxt    = ALL_ZERO;
                    w_score_nxt = bcd_inc(r_score);
                    w_win_nxt   = 1'b1;
                end else begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_HIT: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_hold_nxt = {HOLD_W{1'b0}};
                    if (r_lives == 2'd0) begin
                        w_state_nxt = ST_OVER;
                    end else begin
                        w_state_nxt = ST_PLAY;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            ST_OVER: begin
                if (i_restart) begin
                    w_state_nxt = ST_HOLD;
                    w_hold_nxt  = {HOLD_W{1'b0}};
                    w_lives_nxt = 2'(LIVES_INIT);
                    w_score_nxt = 8'h00;
                    w_sh_nxt    = ALL_ZERO;
                end else begin
                    w_state_nxt = ST_OVER;
                end
            end
            default: begin
                w_state_nxt = ST_HOLD;
                w_hold_nxt  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // LED lane built from the next state so the registered output lines up
    // with the state, lane and counter it describes.
    always_comb begin
        w_led_nxt = ALL_ZERO;
        case (w_state_nxt)
            ST_PLAY: w_led_nxt = i_frog | (w_sh_nxt & SAFE);
            ST_HIT: begin
                if (w_hold_nxt[1]) begin
                    w_led_nxt = ALL_ONES;
                end else begin
                    w_led_nxt = ALL_ZERO;
                end
            end
            ST_HOLD: w_led_nxt = i_frog;
            ST_OVER: w_led_nxt = w_sh_nxt & SAFE;
            default: w_led_nxt = ALL_ZERO;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HOLD;
            r_hold_cnt   <= {HOLD_W{1'b0}};
            r_tick_cnt   <= {TICK_W{1'b0}};
            r_lfsr       <= LFSR_SEED;
            r_sh         <= ALL_ZERO;
            r_lives      <= 2'(LIVES_INIT);
            r_score      <= 8'h00;
            r_frog_reset <= 1'b1;
            r_led        <= ALL_ZERO;
            r_hit_pulse  <= 1'b0;
            r_win_pulse  <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_tick_cnt   <= w_tick_nxt;
            r_lfsr       <= w_lfsr_nxt;
            r_sh         <= w_sh_nxt;
            r_lives      <= w_lives_nxt;
            r_score      <= w_score_nxt;
            r_frog_reset <= (w_state_nxt != ST_PLAY);
            r_led        <= w_led_nxt;
            r_hit_pulse  <= w_hit_nxt;
            r_win_pulse  <= w_win_nxt;
            r_game_over  <= (w_state_nxt == ST_OVER);
        end
    end

    assign o_frog_reset = r_frog_reset;
    assign o_hazard     = w_hazard;
    assign o_led        = r_led;
    assign o_lives      = r_lives;
    assign o_score_bcd  = r_score;
    assign o_hit_pulse  = r_hit_pulse;
    assign o_win_pulse  = r_win_pulse;
    assign o_game_over  = r_game_over;

endmodule

// File: tb/tb_frog_referee.sv
// ---------------------------------------------------------------------------
// tb_frog_referee
// Self-checking bench for frog_referee (TICK_DIV=4, HOLD_CYCLES=4,
// LIVES_INIT=3). A behavioural game model pushes the expected outputs for
// every clock into a queue as stimulus is applied; the entry is popped and
// compared after the edge. Directed checks cover the scenario milestones.
// ---------------------------------------------------------------------------
module tb_frog_referee;

    localparam logic [18:0] SAFE  = 19'h3FFFE;
    localparam logic [18:0] GOAL  = 19'h40000;
    localparam logic [1:0]  S_HOLD = 2'd0;
    localparam logic [1:0]  S_PLAY = 2'd1;
    localparam logic [1:0]  S_HIT  = 2'd2;
    localparam logic [1:0]  S_OVER = 2'd3;

    typedef struct {
        logic        frog_reset;
        logic [18:0] hazard;
        logic [18:0] led;
        logic [1:0]  lives;
        logic [7:0]  score;
        logic        hit;
        logic        win;
        logic        game_over;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [18:0] frog;
    logic        restart;
    logic        o_frog_reset;
    logic [18:0] o_hazard;
    logic [18:0] o_led;
    logic [1:0]  o_lives;
    logic [7:0]  o_score_bcd;
    logic        o_hit_pulse;
    logic        o_win_pulse;
    logic        o_game_over;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // model state
    logic [1:0]  m_state = S_HOLD;
    int          m_hold  = 0;
    int          m_tick  = 0;
    logic [7:0]  m_lfsr  = 8'hA5;
    logic [18:0] m_sh    = 19'd0;
    int          m_lives = 3;
    logic [7:0]  m_score = 8'h00;

    frog_referee #(
        .N_CELLS(19), .TICK_DIV(4), .HOLD_CYCLES(4), .LIVES_INIT(3), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .i_frog(frog), .i_restart(restart),
        .o_frog_reset(o_frog_reset), .o_hazard(o_hazard), .o_led(o_led),
        .o_lives(o_lives), .o_score_bcd(o_score_bcd), .o_hit_pulse(o_hit_pulse),
        .o_win_pulse(o_win_pulse), .o_game_over(o_game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the reference model by one clock edge and queue its outputs.
    task automatic model_step();
        exp_t        e;
        logic [18:0] hz;
        logic [18:0] n_sh;
        logic [1:0]  n_state;
        logic [7:0]  n_lfsr;
        int          n_hold;
        int          n_tick;
        int          sc;
        logic        tick;
        logic        coll;
        logic        nb;
        logic        hit;
        logic        win;
        hit = 1'b0;
        win = 1'b0;
        if (rst) begin
            m_state = S_HOLD; m_hold = 0; m_tick = 0; m_lfsr = 8'hA5;
            m_sh = 19'd0; m_lives = 3; m_score = 8'h00;
        end else begin
            hz      = m_sh & SAFE;
            coll    = |(frog & hz);
            tick    = (m_state == S_PLAY) && (m_tick == 3);
            nb      = m_lfsr[1] & m_lfsr[0] & ~m_sh[18] & ~m_sh[17];
            n_state = m_state;
            n_hold  = m_hold;
            n_sh    = m_sh;
            n_tick  = (m_state == S_PLAY) ? (tick ? 0 : m_tick + 1) : 0;
            if (m_lfsr == 8'h00) n_lfsr = 8'hA5;
            else if (tick) n_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            else n_lfsr = m_lfsr;
            case (m_state)
                S_HOLD: begin
                    if (m_hold == 3) begin n_state = S_PLAY; n_hold = 0; end
                    else n_hold = m_hold + 1;
                end
                S_PLAY: begin
                    if (tick) n_sh = {nb, m_sh[18:1]};
                    if (coll) begin
                        n_state = S_HIT; m_lives = m_lives - 1; hit = 1'b1;
                    end else if (frog[18]) begin
                        n_state = S_HOLD; n_sh = 19'd0; win = 1'b1;
                        sc = (int'(m_score[7:4]) * 10 + int'(m_score[3:0]) + 1) % 100;
                        m_score = {4'(sc / 10), 4'(sc % 10)};
                    end
                end
                S_HIT: begin
                    if (m_hold == 3) begin
                        n_hold = 0;
                        n_state = (m_lives == 0) ? S_OVER : S_PLAY;
                    end else n_hold = m_hold + 1;
                end
                default: begin
                    if (restart) begin
                        m_lives = 3; m_score = 8'h00; n_sh = 19'd0; n_state = S_HOLD; n_hold = 0;
                    end
                end
            endcase
            m_state = n_state; m_hold = n_hold; m_tick = n_tick; m_lfsr = n_lfsr; m_sh = n_sh;
        end
        e.hazard     = m_sh & SAFE;
        e.frog_reset = (m_state != S_PLAY);
        e.game_over  = (m_state == S_OVER);
        e.lives      = 2'(m_lives);
        e.score      = m_score;
        e.hit        = hit;
        e.win        = win;
        if (rst) e.led = 19'd0;
        else begin
            case (m_state)
                S_PLAY:  e.led = frog | e.hazard;
                S_HIT:   e.led = ((m_hold & 2) != 0) ? 19'h7FFFF : 19'd0;
                S_HOLD:  e.led = frog;
                default: e.led = e.hazard;
            endcase
        end
        sb_q.push_back(e);
    endtask

    task automatic sb_compare();
        exp_t e;
        chk_val("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk_val("frog_reset", o_frog_reset, e.frog_reset);
            chk_val("hazard", o_hazard, e.hazard);
            chk_val("led", o_led, e.led);
            chk_val("lives", o_lives, e.lives);
            chk_val("score", o_score_bcd, e.score);
            chk_val("hit_pulse", o_hit_pulse, e.hit);
            chk_val("win_pulse", o_win_pulse, e.win);
            chk_val("game_over", o_game_over, e.game_over);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        sb_compare();
    endtask

    task automatic count_hold(input string tag);
        int cnt = 0;
        while (o_frog_reset && cnt < 20) begin
            cycle();
            cnt++;
        end
        chk_val(tag, cnt, 4);
    endtask

    // Wait for play with a hazard on the lane, then step the frog onto it.
    task automatic do_collision(input string tag, input bit multi);
        int          guard = 0;
        logic [18:0] hz;
        frog = 19'd1;
        while (!(o_frog_reset == 1'b0 && o_hazard != 19'd0) && guard < 500) begin
            cycle();
            guard++;
        end
        chk_val({tag, "_wait"}, (guard < 500), 1);
        if (guard < 500) begin
            hz   = o_hazard;
            frog = multi ? (hz | 19'd1) : (hz & (~hz + 19'd1));
            cycle();
            chk_val({tag, "_pulse"}, o_hit_pulse, 1);
            frog = 19'd1;
        end
    endtask

    task automatic do_win(input string tag);
        int guard = 0;
        frog = GOAL;
        cycle();
        while (!o_win_pulse && guard < 50) begin
            cycle();
            guard++;
        end
        chk_val({tag, "_wait"}, (guard < 50), 1);
    endtask

    initial begin
        int          seen;
        logic [18:0] hz;
        rst = 1'b1; frog = 19'd1; restart = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        chk_val("rst_lives", o_lives, 2'd3);
        chk_val("rst_score", o_score_bcd, 8'h00);
        chk_val("rst_hazard", o_hazard, 19'd0);
        chk_val("rst_frog_reset", o_frog_reset, 1'b1);
        count_hold("rst_hold_len");

        // free play from the start cell: hazards scroll with safe spacing
        seen = 0;
        for (int i = 0; i < 160; i++) begin
            cycle();
            hz = o_hazard;
            chk_val("spacing", (|(hz & (hz >> 1))) | (|(hz & (hz >> 2))), 1'b0);
            chk_val("hz_ends", {hz[18], hz[0]}, 2'b00);
            if (hz != 19'd0) seen = 1;
        end
        chk_val("hz_seen", seen, 1);

        do_collision("hit1", 1'b0);
        chk_val("hit1_lives", o_lives, 2'd2);
        count_hold("hit_hold_len");

        for (int w = 1; w <= 100; w++) begin
            do_win("win");
            if (w == 9)   chk_val("score_09", o_score_bcd, 8'h09);
            if (w == 10)  chk_val("score_10", o_score_bcd, 8'h10);
            if (w == 99)  chk_val("score_99", o_score_bcd, 8'h99);
            if (w == 100) chk_val("score_wrap", o_score_bcd, 8'h00);
        end
        frog = 19'd1;

        do_collision("hit2", 1'b1);
        chk_val("hit2_lives", o_lives, 2'd1);
        do_collision("hit3", 1'b0);
        chk_val("hit3_lives", o_lives, 2'd0);
        for (int i = 0; i < 12; i++) cycle();
        chk_val("over_flag", o_game_over, 1'b1);
        chk_val("over_frog_reset", o_frog_reset, 1'b1);

        restart = 1'b1;
        cycle();
        restart = 1'b0;
        chk_val("restart_lives", o_lives, 2'd3);
        chk_val("restart_score", o_score_bcd, 8'h00);
        chk_val("restart_over", o_game_over, 1'b0);
        count_hold("restart_hold_len");

        do_win("win_after_restart");
        frog = 19'd1;
        chk_val("score_01", o_score_bcd, 8'h01);
        do_collision("hit4", 1'b0);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk_val("midhit_lives", o_lives, 2'd3);
        chk_val("midhit_score", o_score_bcd, 8'h00);
        chk_val("midhit_frog_reset", o_frog_reset, 1'b1);
        chk_val("midhit_pulses", {o_hit_pulse, o_win_pulse}, 2'b00);
        count_hold("midhit_hold_len");
        for (int i = 0; i < 8; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
